// File: rtl/seq_1010_scan_ctrl.sv
// Word-level controller that scans each accepted word MSB-first for "1010".
// Define SEQ_SCAN_CARRY_EN to carry detector state across word boundaries.
module seq_1010_scan_ctrl #(
  parameter int W     = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_hits,
  output logic [W-1:0]     out_hit_mask,
  output logic             busy
);

  localparam int BW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    DA,
    DB,
    DC,
    DD
  } det_t;

  state_t          state, state_nx;
  det_t            det, det_nx;
  logic [W-1:0]    sr;
  logic [BW-1:0]   cnt;
  logic [CNT_W-1:0] hits;
  logic [W-1:0]    mask;
  logic            w;
  logic            z;
  logic            accept;

  assign w            = sr[W-1];
  assign accept       = (state == IDLE) && in_valid;
  assign out_hits     = hits;
  assign out_hit_mask = mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      det   <= DA;
    end else begin
      state <= state_nx;
      det   <= det_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    det_nx    = det;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    z         = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nx = SHIFT;
`ifndef SEQ_SCAN_CARRY_EN
          det_nx = DA;
`endif
        end
      end
      SHIFT: begin
        busy = 1'b1;
        unique case (det)
          DA: det_nx = w ? DB : DA;
          DB: det_nx = w ? DB : DC;
          DC: det_nx = w ? DD : DA;
          DD: begin
            det_nx = w ? DB : DC;
            z      = !w;
          end
        endcase
        if (cnt == '0)
          state_nx = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Result registers double as the working accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr   <= '0;
      cnt  <= '0;
      hits <= '0;
      mask <= '0;
    end else if (accept) begin
      sr   <= in_data;
      cnt  <= BW'(W - 1);
      hits <= '0;
      mask <= '0;
    end else if (state == SHIFT) begin
      sr  <= {sr[W-2:0], 1'b0};
      cnt <= cnt - 1'b1;
      if (z) begin
        mask[cnt] <= 1'b1;
        if (hits != '1)
          hits <= hits + 1'b1;
      end
    end
  end

endmodule
